// File: rtl/ir_scan_sched.sv
// ---------------------------------------------------------------------------
// ir_scan_sched
//
// Owns the shared A2D converter and the three IR emitter enables for one
// line-sensor scan. On a scan request the six IR channels are visited pair by
// pair: the pair's emitter is PWM-enabled, allowed to settle, then two
// conversions are run and each result is handed to the consumer through a
// one-cycle write strobe tagged with its slot index.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   scan_req_i   level request, accepted only while idle
//   abort_i      synchronous abort of the scan in progress
//   cnv_cmplt_i  A2D conversion finished
//   A2D_res_i    A2D result, valid while cnv_cmplt_i is high
//   strt_cnv_o   one-cycle conversion start pulse
//   chnnl_o      A2D channel select
//   IR_in_en_o   inner emitter PWM enable
//   IR_mid_en_o  middle emitter PWM enable
//   IR_out_en_o  outer emitter PWM enable
//   res_wr_o     one-cycle result strobe
//   res_idx_o    result slot 0..5
//   res_data_o   result value, held between strobes
//   busy_o       high whenever a scan is in progress
//   scan_done_o  one-cycle pulse together with the slot 5 strobe
//   cnv_err_o    sticky conversion-timeout flag, cleared by the next scan
// ---------------------------------------------------------------------------
module ir_scan_sched #(
    parameter int unsigned SETTLE_CYC  = 4096,
    parameter int unsigned CNV_TIMEOUT = 1023,
    parameter logic [7:0]  IR_DUTY     = 8'd192
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scan_req_i,
    input  logic        abort_i,
    input  logic        cnv_cmplt_i,
    input  logic [11:0] A2D_res_i,
    output logic        strt_cnv_o,
    output logic [2:0]  chnnl_o,
    output logic        IR_in_en_o,
    output logic        IR_mid_en_o,
    output logic        IR_out_en_o,
    output logic        res_wr_o,
    output logic [2:0]  res_idx_o,
    output logic [11:0] res_data_o,
    output logic        busy_o,
    output logic        scan_done_o,
    output logic        cnv_err_o
);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        CONV,
        WAIT,
        WRITE
    } state_t;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] TIMEOUT_LIM = 16'(CNV_TIMEOUT);
    localparam logic [2:0]  LAST_SLOT   = 3'd5;

    // Slot-to-channel map; the channel numbering follows the board wiring,
    // not the slot order.
    function automatic logic [2:0] slotChannel(input logic [2:0] slot);
        case (slot)
            3'd0:    return 3'd1;
            3'd1:    return 3'd0;
            3'd2:    return 3'd4;
            3'd3:    return 3'd2;
            3'd4:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [1:0]  pair_q, pair_d;
    logic [2:0]  slot_q, slot_d;
    logic [15:0] settleCnt_q, settleCnt_d;
    logic [15:0] timeoutCnt_q, timeoutCnt_d;
    logic [7:0]  pwmCnt_q, pwmCnt_d;
    logic        strtCnv_q, strtCnv_d;
    logic [2:0]  chnnl_q, chnnl_d;
    logic [2:0]  irEn_q, irEn_d;
    logic        resWr_q, resWr_d;
    logic [2:0]  resIdx_q, resIdx_d;
    logic [11:0] resData_q, resData_d;
    logic        scanDone_q, scanDone_d;
    logic        cnvErr_q, cnvErr_d;
    logic        busy_q, busy_d;
    logic [2:0]  nextSlot;
    logic        emitActive;

    assign nextSlot = slot_q + 3'd1;

    // Next-state and next-output logic. All outputs are registered, so the
    // values computed here describe what the block shows in the next cycle.
    always_comb begin
        state_d      = state_q;
        pair_d       = pair_q;
        slot_d       = slot_q;
        settleCnt_d  = settleCnt_q;
        timeoutCnt_d = timeoutCnt_q;
        pwmCnt_d     = pwmCnt_q + 8'd1;
        strtCnv_d    = 1'b0;
        chnnl_d      = chnnl_q;
        resWr_d      = 1'b0;
        resIdx_d     = resIdx_q;
        resData_d    = resData_q;
        scanDone_d   = 1'b0;
        cnvErr_d     = cnvErr_q;

        case (state_q)
            IDLE: begin
                if (scan_req_i) begin
                    state_d     = SETTLE;
                    pair_d      = 2'd0;
                    slot_d      = 3'd0;
                    settleCnt_d = 16'd0;
                    cnvErr_d    = 1'b0;
                    chnnl_d     = slotChannel(3'd0);
                end
            end
            SETTLE: begin
                if (settleCnt_q == SETTLE_LAST) begin
                    state_d      = CONV;
                    strtCnv_d    = 1'b1;
                    timeoutCnt_d = 16'd0;
                end else begin
                    settleCnt_d = settleCnt_q + 16'd1;
                end
            end
            CONV: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A completion seen in the timeout cycle still counts as a
                // real result, so it is tested first.
                if (cnv_cmplt_i) begin
                    state_d    = WRITE;
                    resData_d  = A2D_res_i;
                    resWr_d    = 1'b1;
                    resIdx_d   = slot_q;
                    scanDone_d = (slot_q == LAST_SLOT);
                end else if (timeoutCnt_q == TIMEOUT_LIM) begin
                    state_d    = WRITE;
                    resData_d  = 12'hFFF;
                    cnvErr_d   = 1'b1;
                    resWr_d    = 1'b1;
                    resIdx_d   = slot_q;
                    scanDone_d = (slot_q == LAST_SLOT);
                end else begin
                    timeoutCnt_d = timeoutCnt_q + 16'd1;
                end
            end
            WRITE: begin
                if (slot_q == LAST_SLOT) begin
                    state_d = IDLE;
                end else if (slot_q[0]) begin
                    // Pair finished: the next pair needs its own settle time.
                    state_d     = SETTLE;
                    pair_d      = pair_q + 2'd1;
                    slot_d      = nextSlot;
                    settleCnt_d = 16'd0;
                    chnnl_d     = slotChannel(nextSlot);
                end else begin
                    // Second channel of the same pair: emitter already settled.
                    state_d      = CONV;
                    slot_d       = nextSlot;
                    strtCnv_d    = 1'b1;
                    timeoutCnt_d = 16'd0;
                    chnnl_d      = slotChannel(nextSlot);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort wins over everything above and discards any pending result.
        if (abort_i && (state_q != IDLE)) begin
            state_d    = IDLE;
            strtCnv_d  = 1'b0;
            chnnl_d    = chnnl_q;
            resWr_d    = 1'b0;
            resIdx_d   = resIdx_q;
            resData_d  = resData_q;
            scanDone_d = 1'b0;
            cnvErr_d   = cnvErr_q;
        end
    end

    // Emitters run only while a pair is being settled or converted; the
    // write cycle and idle keep every emitter dark.
    always_comb begin
        emitActive = (state_d == SETTLE) || (state_d == CONV) || (state_d == WAIT);
        busy_d     = (state_d != IDLE);
        irEn_d     = 3'b000;
        if (emitActive && (pwmCnt_d < IR_DUTY)) begin
            irEn_d[pair_d] = 1'b1;
        end
    end

    // Single state register for the sequencer and all of its outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            pair_q       <= 2'd0;
            slot_q       <= 3'd0;
            settleCnt_q  <= 16'd0;
            timeoutCnt_q <= 16'd0;
            pwmCnt_q     <= 8'd0;
            strtCnv_q    <= 1'b0;
            chnnl_q      <= 3'd0;
            irEn_q       <= 3'b000;
            resWr_q      <= 1'b0;
            resIdx_q     <= 3'd0;
            resData_q    <= 12'd0;
            scanDone_q   <= 1'b0;
            cnvErr_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pair_q       <= pair_d;
            slot_q       <= slot_d;
            settleCnt_q  <= settleCnt_d;
            timeoutCnt_q <= timeoutCnt_d;
            pwmCnt_q     <= pwmCnt_d;
            strtCnv_q    <= strtCnv_d;
            chnnl_q      <= chnnl_d;
            irEn_q       <= irEn_d;
            resWr_q      <= resWr_d;
            resIdx_q     <= resIdx_d;
            resData_q    <= resData_d;
            scanDone_q   <= scanDone_d;
            cnvErr_q     <= cnvErr_d;
            busy_q       <= busy_d;
        end
    end

    assign strt_cnv_o  = strtCnv_q;
    assign chnnl_o     = chnnl_q;
    assign IR_in_en_o  = irEn_q[0];
    assign IR_mid_en_o = irEn_q[1];
    assign IR_out_en_o = irEn_q[2];
    assign res_wr_o    = resWr_q;
    assign res_idx_o   = resIdx_q;
    assign res_data_o  = resData_q;
    assign busy_o      = busy_q;
    assign scan_done_o = scanDone_q;
    assign cnv_err_o   = cnvErr_q;

endmodule
